// File: rtl/doom_pkg.sv
// Shared encodings for the camera sequencer: state codes, one-hot views,
// request codes and the small decode helpers used by the top-level FSM.
package doom_pkg;

  localparam logic [2:0] ST_FWD   = 3'd0;
  localparam logic [2:0] ST_LEFT  = 3'd1;
  localparam logic [2:0] ST_RIGHT = 3'd2;
  localparam logic [2:0] ST_F2L   = 3'd3;
  localparam logic [2:0] ST_L2F   = 3'd4;
  localparam logic [2:0] ST_F2R   = 3'd5;
  localparam logic [2:0] ST_R2F   = 3'd6;

  localparam logic [2:0] VIEW_FWD   = 3'b001;
  localparam logic [2:0] VIEW_LEFT  = 3'b010;
  localparam logic [2:0] VIEW_RIGHT = 3'b100;

  typedef enum logic [2:0] {
    S_FWD   = ST_FWD,
    S_LEFT  = ST_LEFT,
    S_RIGHT = ST_RIGHT,
    S_F2L   = ST_F2L,
    S_L2F   = ST_L2F,
    S_F2R   = ST_F2R,
    S_R2F   = ST_R2F
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_L    = 2'd1,
    REQ_R    = 2'd2,
    REQ_U    = 2'd3
  } req_t;

  // Recentre wins outright; simultaneous left+right cancel each other.
  function automatic req_t resolve_req(input logic l, input logic r, input logic u);
    req_t q;
    q = REQ_NONE;
    if (u)            q = REQ_U;
    else if (l && !r) q = REQ_L;
    else if (r && !l) q = REQ_R;
    return q;
  endfunction

  function automatic state_t rest_next(input state_t s, input req_t q);
    state_t n;
    n = s;
    case (s)
      S_FWD:   if (q == REQ_L) n = S_F2L; else if (q == REQ_R) n = S_F2R;
      S_LEFT:  if (q == REQ_R || q == REQ_U) n = S_L2F;
      S_RIGHT: if (q == REQ_L || q == REQ_U) n = S_R2F;
      default: n = s;
    endcase
    return n;
  endfunction

  function automatic state_t dest_of(input state_t s);
    state_t n;
    case (s)
      S_F2L:   n = S_LEFT;
      S_F2R:   n = S_RIGHT;
      S_L2F,
      S_R2F:   n = S_FWD;
      default: n = s;
    endcase
    return n;
  endfunction

  // Source view: a transition keeps showing where it started from.
  function automatic logic [2:0] view_of(input state_t s);
    logic [2:0] v;
    case (s)
      S_LEFT, S_L2F:  v = VIEW_LEFT;
      S_RIGHT, S_R2F: v = VIEW_RIGHT;
      default:        v = VIEW_FWD;
    endcase
    return v;
  endfunction

  function automatic logic is_turn(input state_t s);
    return (s == S_F2L) || (s == S_L2F) || (s == S_F2R) || (s == S_R2F);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector: press is high for the one cycle in which
// level is high and its registered previous value is low.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic press
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= level;
  end

  assign press = level & ~prev_q;

endmodule

// File: rtl/camera_sequencer.sv
// Camera view sequencer: rest views FWD/LEFT/RIGHT joined by timed turn states.
// Define CAMERA_SEQ_TURN_QUEUE_EN to keep one press made during a turn.
module camera_sequencer
  import doom_pkg::*;
#(
  parameter int TURN_CYCLES = 4,
  parameter int PHASE_W     = 8
) (
  input  logic               ClkPort,
  input  logic               Reset,
  input  logic               BtnL,
  input  logic               BtnR,
  input  logic               BtnU,
  output logic [2:0]         camera_view,
  output logic               turning,
  output logic [PHASE_W-1:0] turn_phase,
  output logic [2:0]         turn_target,
  output logic [2:0]         dbg_state
);

  logic press_l, press_r, press_u;

  btn_edge u_edge_l (.clk(ClkPort), .rst_n(Reset), .level(BtnL), .press(press_l));
  btn_edge u_edge_r (.clk(ClkPort), .rst_n(Reset), .level(BtnR), .press(press_r));
  btn_edge u_edge_u (.clk(ClkPort), .rst_n(Reset), .level(BtnU), .press(press_u));

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  req_t               live_req, eval_req;
  logic               last_phase;

  assign live_req   = resolve_req(press_l, press_r, press_u);
  assign last_phase = (phase_q == PHASE_W'(TURN_CYCLES - 1));

`ifdef CAMERA_SEQ_TURN_QUEUE_EN
  logic pend_valid_q, pend_valid_d;
  req_t pend_req_q, pend_req_d;

  always_ff @(posedge ClkPort or negedge Reset) begin
    if (!Reset) begin
      pend_valid_q <= 1'b0;
      pend_req_q   <= REQ_NONE;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_req_q   <= pend_req_d;
    end
  end

  // A stored press outranks a fresh one in the first rest cycle.
  assign eval_req = pend_valid_q ? pend_req_q : live_req;
`else
  assign eval_req = live_req;
`endif

  always_ff @(posedge ClkPort or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_FWD;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
`ifdef CAMERA_SEQ_TURN_QUEUE_EN
    pend_valid_d = pend_valid_q;
    pend_req_d   = pend_req_q;
`endif
    if (is_turn(state_q)) begin
      if (last_phase) begin
        phase_d = '0;
        state_d = dest_of(state_q);
      end else begin
        phase_d = phase_q + PHASE_W'(1);
      end
`ifdef CAMERA_SEQ_TURN_QUEUE_EN
      if (!pend_valid_q && live_req != REQ_NONE) begin
        pend_valid_d = 1'b1;
        pend_req_d   = live_req;
      end
`endif
    end else begin
      phase_d = '0;
      state_d = rest_next(state_q, eval_req);
`ifdef CAMERA_SEQ_TURN_QUEUE_EN
      pend_valid_d = 1'b0;
      pend_req_d   = REQ_NONE;
`endif
    end
  end

  assign camera_view = view_of(state_q);
  assign turning     = is_turn(state_q);
  assign turn_phase  = phase_q;
  assign turn_target = view_of(is_turn(state_q) ? dest_of(state_q) : state_q);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_camera_sequencer.sv
// Directed bench for camera_sequencer with TURN_CYCLES=4; expected output
// words are {turning, turn_phase, turn_target, camera_view}.
module tb_camera_sequencer;
  import doom_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0;
  logic [2:0]  camera_view, turn_target, dbg_state;
  logic        turning;
  logic [7:0]  turn_phase;
  logic [14:0] obs, exp_v;
  int          n_cmp = 0;
  int          n_err = 0;

  camera_sequencer #(.TURN_CYCLES(4), .PHASE_W(8)) dut (
    .ClkPort(clk), .Reset(rst_n), .BtnL(btn_l), .BtnR(btn_r), .BtnU(btn_u),
    .camera_view(camera_view), .turning(turning), .turn_phase(turn_phase),
    .turn_target(turn_target), .dbg_state(dbg_state)
  );

  assign obs = {turning, turn_phase, turn_target, camera_view};

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    exp_v = {1'b0, 8'd0, VIEW_FWD, VIEW_FWD};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL reset_hold got=%h exp=%h", obs, exp_v); end
    tick(); tick();
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick();
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL idle_fwd%0d got=%h exp=%h", j, obs, exp_v); end
    end
  endtask

  task automatic test_turn_left();
    btn_l = 1'b1; tick(); btn_l = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_v = {1'b1, 8'(i), VIEW_LEFT, VIEW_FWD};
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL f2l_ph%0d got=%h exp=%h", i, obs, exp_v); end
      tick();
    end
    exp_v = {1'b0, 8'd0, VIEW_LEFT, VIEW_LEFT};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL left_rest got=%h exp=%h", obs, exp_v); end
    n_cmp++;
    if (dbg_state !== ST_LEFT) begin n_err++; $display("FAIL left_state got=%0d exp=%0d", dbg_state, ST_LEFT); end
  endtask

  task automatic test_turn_right();
    btn_r = 1'b1; tick(); btn_r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_v = {1'b1, 8'(i), VIEW_FWD, VIEW_LEFT};
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL l2f_ph%0d got=%h exp=%h", i, obs, exp_v); end
      tick();
    end
    exp_v = {1'b0, 8'd0, VIEW_FWD, VIEW_FWD};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL l2f_done got=%h exp=%h", obs, exp_v); end
    btn_r = 1'b1; tick(); btn_r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_v = {1'b1, 8'(i), VIEW_RIGHT, VIEW_FWD};
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL f2r_ph%0d got=%h exp=%h", i, obs, exp_v); end
      tick();
    end
    exp_v = {1'b0, 8'd0, VIEW_RIGHT, VIEW_RIGHT};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL right_rest got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_hold_u();
    btn_u = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin
      exp_v = {1'b1, 8'(i), VIEW_FWD, VIEW_RIGHT};
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL r2f_ph%0d got=%h exp=%h", i, obs, exp_v); end
      tick();
    end
    exp_v = {1'b0, 8'd0, VIEW_FWD, VIEW_FWD};
    for (int j = 0; j < 5; j++) begin
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL hold_u_rest%0d got=%h exp=%h", j, obs, exp_v); end
      tick();
    end
    btn_u = 1'b0;
    tick(); tick();
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL hold_u_after got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_simultaneous();
    btn_l = 1'b1; btn_r = 1'b1; tick();
    exp_v = {1'b0, 8'd0, VIEW_FWD, VIEW_FWD};
    for (int j = 0; j < 3; j++) begin
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL l_and_r%0d got=%h exp=%h", j, obs, exp_v); end
      tick();
    end
    btn_l = 1'b0; btn_r = 1'b0; tick();
  endtask

  task automatic test_press_during_turn();
    btn_l = 1'b1; tick(); btn_l = 1'b0;
    tick(); tick();
    exp_v = {1'b1, 8'd2, VIEW_LEFT, VIEW_FWD};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL mid_ph2 got=%h exp=%h", obs, exp_v); end
    btn_r = 1'b1; tick(); btn_r = 1'b0;
    tick();
    exp_v = {1'b0, 8'd0, VIEW_LEFT, VIEW_LEFT};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL mid_first_rest got=%h exp=%h", obs, exp_v); end
    tick();
`ifdef CAMERA_SEQ_TURN_QUEUE_EN
    for (int i = 0; i < 4; i++) begin
      exp_v = {1'b1, 8'(i), VIEW_FWD, VIEW_LEFT};
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL queued_l2f_ph%0d got=%h exp=%h", i, obs, exp_v); end
      tick();
    end
`else
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL dropped_stays_left got=%h exp=%h", obs, exp_v); end
    btn_u = 1'b1; tick(); btn_u = 1'b0;
    repeat (4) tick();
`endif
    exp_v = {1'b0, 8'd0, VIEW_FWD, VIEW_FWD};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL mid_end_fwd got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_reset_mid();
    btn_l = 1'b1; tick(); btn_l = 1'b0; tick();
    exp_v = {1'b1, 8'd1, VIEW_LEFT, VIEW_FWD};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL pre_reset_ph1 got=%h exp=%h", obs, exp_v); end
    rst_n = 1'b0; #1;
    exp_v = {1'b0, 8'd0, VIEW_FWD, VIEW_FWD};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL abort_reset got=%h exp=%h", obs, exp_v); end
    n_cmp++;
    if (dbg_state !== ST_FWD) begin n_err++; $display("FAIL abort_state got=%0d exp=%0d", dbg_state, ST_FWD); end
    btn_l = 1'b1; tick();
    rst_n = 1'b1; tick();
    exp_v = {1'b1, 8'd0, VIEW_LEFT, VIEW_FWD};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL held_across_release got=%h exp=%h", obs, exp_v); end
    btn_l = 1'b0;
    repeat (4) tick();
    exp_v = {1'b0, 8'd0, VIEW_LEFT, VIEW_LEFT};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL release_left got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_ignored();
    btn_l = 1'b1; tick(); btn_l = 1'b0; tick();
    exp_v = {1'b0, 8'd0, VIEW_LEFT, VIEW_LEFT};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL left_plus_l got=%h exp=%h", obs, exp_v); end
    btn_u = 1'b1; tick(); btn_u = 1'b0;
    repeat (4) tick();
    exp_v = {1'b0, 8'd0, VIEW_FWD, VIEW_FWD};
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL left_plus_u got=%h exp=%h", obs, exp_v); end
    btn_u = 1'b1; tick(); btn_u = 1'b0; tick();
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL fwd_plus_u got=%h exp=%h", obs, exp_v); end
  endtask

  initial begin
    test_reset();
    test_turn_left();
    test_turn_right();
    test_hold_u();
    test_simultaneous();
    test_press_during_turn();
    test_reset_mid();
    test_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
